// File: rtl/exec_sequencer_if.sv
// Fetch-side instruction handshake for exec_sequencer.
// master = instruction fetch, slave = sequencer.
interface exec_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle RV32 control sequencer: decode, EXEC, optional load wait/writeback, PC.
// Optional retired-instruction counter is built only with EXEC_SEQ_PERF_CNT_EN defined.
module exec_sequencer #(
  parameter int                 WIDTH    = 32,
  parameter int                 MEM_LAT  = 1,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  exec_sequencer_if.slave  fetch,
  output logic [WIDTH-1:0] pc,
  output logic [6:0]       opcode,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [4:0]       RD,
  output logic [11:0]      Imm_reg,
  output logic [4:0]       Shamt,
  output logic             reg_write_en,
  output logic             mem_write_en,
  output logic             read_en,
  output logic             retire,
  output logic             illegal,
  output logic [31:0]      instret_count
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam int         CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, LD_WAIT, LD_WB} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] pc_nx;
  logic             rdy_nx, rwe_nx, mwe_nx, ren_nx, ret_nx, ill_nx;
  logic             accept;
  logic             in_store;

  assign in_store = (fetch.instr[6:0] == OPC_STORE);

  // Every output is registered, so next-cycle strobes are computed here
  // from the transition being taken rather than from the current state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    rdy_nx   = 1'b0;
    rwe_nx   = 1'b0;
    mwe_nx   = 1'b0;
    ren_nx   = 1'b0;
    ret_nx   = 1'b0;
    ill_nx   = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        rdy_nx = 1'b1;
        if (fetch.instr_valid && fetch.instr_ready) begin
          accept   = 1'b1;
          rdy_nx   = 1'b0;
          state_nx = EXEC;
          case (fetch.instr[6:0])
            OPC_OP, OPC_OPIMM: begin rwe_nx = 1'b1; ret_nx = 1'b1; end
            OPC_STORE:         begin mwe_nx = 1'b1; ret_nx = 1'b1; end
            OPC_LOAD:          ren_nx = 1'b1;
            default:           ill_nx = 1'b1;
          endcase
        end
      end
      EXEC: begin
        if (opcode == OPC_LOAD) begin
          state_nx = LD_WAIT;
          ren_nx   = 1'b1;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
          rdy_nx   = 1'b1;
          pc_nx    = pc + WIDTH'(4);
        end
      end
      LD_WAIT: begin
        ren_nx = 1'b1;
        if (cnt == CW'(MEM_LAT - 1)) begin
          state_nx = LD_WB;
          rwe_nx   = 1'b1;
          ret_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      LD_WB: begin
        state_nx = IDLE;
        rdy_nx   = 1'b1;
        pc_nx    = pc + WIDTH'(4);
      end
      default: begin
        state_nx = IDLE;
        rdy_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      pc                <= RESET_PC;
      fetch.instr_ready <= 1'b1;
      reg_write_en      <= 1'b0;
      mem_write_en      <= 1'b0;
      read_en           <= 1'b0;
      retire            <= 1'b0;
      illegal           <= 1'b0;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      pc                <= pc_nx;
      fetch.instr_ready <= rdy_nx;
      reg_write_en      <= rwe_nx;
      mem_write_en      <= mwe_nx;
      read_en           <= ren_nx;
      retire            <= ret_nx;
      illegal           <= ill_nx;
    end
  end

  // Decoded fields are captured only on accept and hold until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode  <= '0;
      Funct3  <= '0;
      Funct7  <= '0;
      RS1     <= '0;
      RS2     <= '0;
      RD      <= '0;
      Imm_reg <= '0;
      Shamt   <= '0;
    end else if (accept) begin
      opcode  <= fetch.instr[6:0];
      Funct3  <= fetch.instr[14:12];
      Funct7  <= fetch.instr[31:25];
      RS1     <= fetch.instr[19:15];
      RS2     <= fetch.instr[24:20];
      RD      <= in_store ? 5'd0 : fetch.instr[11:7];
      Imm_reg <= in_store ? {fetch.instr[31:25], fetch.instr[11:7]} : fetch.instr[31:20];
      Shamt   <= fetch.instr[24:20];
    end
  end

`ifdef EXEC_SEQ_PERF_CNT_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
  assign instret_count = instret_q;
`else
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed RV32 words, hand-computed decode/timing.
module tb_exec_sequencer;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exec_sequencer_if bus ();
  exec_sequencer_if wbus ();

  logic [31:0] pc, icnt, w_pc, w_icnt;
  logic [6:0]  opc, f7, w_opc, w_f7;
  logic [2:0]  f3, w_f3;
  logic [4:0]  rs1, rs2, rd, sh, w_rs1, w_rs2, w_rd, w_sh;
  logic [11:0] imm, w_imm;
  logic        rwe, mwe, ren, ret, ill, w_rwe, w_mwe, w_ren, w_ret, w_ill;

  exec_sequencer #(.WIDTH(32), .MEM_LAT(MEM_LAT), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .fetch(bus), .pc(pc), .opcode(opc), .Funct3(f3), .Funct7(f7),
    .RS1(rs1), .RS2(rs2), .RD(rd), .Imm_reg(imm), .Shamt(sh), .reg_write_en(rwe),
    .mem_write_en(mwe), .read_en(ren), .retire(ret), .illegal(ill), .instret_count(icnt));

  // Second instance exercises PC wrap and the minimum load latency.
  exec_sequencer #(.WIDTH(32), .MEM_LAT(1), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .fetch(wbus), .pc(w_pc), .opcode(w_opc), .Funct3(w_f3), .Funct7(w_f7),
    .RS1(w_rs1), .RS2(w_rs2), .RD(w_rd), .Imm_reg(w_imm), .Shamt(w_sh), .reg_write_en(w_rwe),
    .mem_write_en(w_mwe), .read_en(w_ren), .retire(w_ret), .illegal(w_ill), .instret_count(w_icnt));

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [11:0] imm;
    logic        rwe, mwe, ren, ret, ill;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   n_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [6:0] o, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                              input logic [6:0] fn7, input logic [11:0] im, input logic [4:0] sa,
                              input logic [4:0] flags, input int lat);
    exp_t e;
    e.due = lat; e.pc = p; e.opc = o; e.rd = d; e.rs1 = s1; e.rs2 = s2; e.f3 = fn3;
    e.f7 = fn7; e.imm = im; e.sh = sa;
    {e.rwe, e.mwe, e.ren, e.ret, e.ill} = flags;
    return e;
  endfunction

  // due is the latency in cycles after the accept edge's cycle (0 = first cycle after accept).
  task automatic issue(input logic [31:0] w, input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.instr_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    bus.instr = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    e.due = cyc + e.due;
    if (push) begin
      sb.push_back(e);
      if (e.ret) n_ret++;
    end
  endtask

  // Monitor: every retire or illegal pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (int'(rwe) + int'(mwe) + int'(ill) > 1) begin
        bad++;
        $display("FAIL strobe_excl: got rwe=%0b mwe=%0b ill=%0b want one-hot", rwe, mwe, ill);
      end
      if (ret || ill) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pulse: got ret=%0b ill=%0b want none", ret, ill);
        end else begin
          me = sb.pop_front();
          chk("cycle", cyc, me.due);
          chk("pc", pc, me.pc);
          chk("opcode", {25'd0, opc}, {25'd0, me.opc});
          chk("rd", {27'd0, rd}, {27'd0, me.rd});
          chk("rs1", {27'd0, rs1}, {27'd0, me.rs1});
          chk("rs2", {27'd0, rs2}, {27'd0, me.rs2});
          chk("funct3", {29'd0, f3}, {29'd0, me.f3});
          chk("funct7", {25'd0, f7}, {25'd0, me.f7});
          chk("imm", {20'd0, imm}, {20'd0, me.imm});
          chk("shamt", {27'd0, sh}, {27'd0, me.sh});
          chk("strobes", {27'd0, rwe, mwe, ren, ret, ill},
              {27'd0, me.rwe, me.mwe, me.ren, me.ret, me.ill});
        end
      end
    end
  end

  initial begin
    int   n;
    int   exp_cnt;
    exp_t dummy;
    bus.instr_valid = 1'b0; bus.instr = '0;
    wbus.instr_valid = 1'b0; wbus.instr = '0;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_strobes", {27'd0, rwe, mwe, ren, ret, ill}, 32'd0);
    chk("rst_fields", {opc, rd, imm}, 24'd0);
    chk("rst_cnt", icnt, 32'd0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    @(negedge clk) rst = 1'b1;

    // ADD x3,x1,x2 with explicit ready/pc timing check.
    issue(32'h002081B3, mk(32'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h002, 5'd2, 5'b10010, 0), 1);
    @(negedge clk);
    chk("add_busy_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(negedge clk);
    chk("add_ready_back", {31'd0, bus.instr_ready}, 32'd1);
    chk("add_pc_next", pc, 32'd4);

    // SW x2,8(x1)
    issue(32'h0020A423, mk(32'd4, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'h008, 5'd2, 5'b01010, 0), 1);

    // LW x5,4(x1): read_en window, with a stray valid while busy that must be ignored.
    issue(32'h0040A283, mk(32'd8, 7'h03, 5'd5, 5'd1, 5'd4, 3'd2, 7'd0, 12'h004, 5'd4, 5'b10110, 1 + MEM_LAT), 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ren) n++;
      if (i < 3) begin bus.instr = 32'h0000007F; bus.instr_valid = 1'b1; end
      else bus.instr_valid = 1'b0;
    end
    chk("lw_read_en_len", n, 32'd5);
    chk("lw_rd_hold", {27'd0, rd}, 32'd5);

    // Unsupported opcode: illegal pulse, pc still advances.
    issue(32'h0000007F, mk(32'd12, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'h000, 5'd0, 5'b00001, 0), 1);
    // SLLI x7,x1,3
    issue(32'h00309393, mk(32'd16, 7'h13, 5'd7, 5'd1, 5'd3, 3'd1, 7'd0, 12'h003, 5'd3, 5'b10010, 0), 1);
    // ADD x4,x3,x1 ; ADD x6,x5,x4 ; SUB x8,x1,x2
    issue(32'h00118233, mk(32'd20, 7'h33, 5'd4, 5'd3, 5'd1, 3'd0, 7'd0, 12'h001, 5'd1, 5'b10010, 0), 1);
    issue(32'h00428333, mk(32'd24, 7'h33, 5'd6, 5'd5, 5'd4, 3'd0, 7'd0, 12'h004, 5'd4, 5'b10010, 0), 1);
    issue(32'h40208433, mk(32'd28, 7'h33, 5'd8, 5'd1, 5'd2, 3'd0, 7'h20, 12'h402, 5'd2, 5'b10010, 0), 1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("sb_drain", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk("final_pc", pc, 32'd32);
`ifdef EXEC_SEQ_PERF_CNT_EN
    exp_cnt = n_ret;
`else
    exp_cnt = 0;
`endif
    chk("instret", icnt, exp_cnt);

    // Reset asserted while the load sits in LD_WAIT.
    issue(32'h0040A283, dummy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midld_in_wait", {31'd0, ren}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midld_pc", pc, 32'h0);
    chk("midld_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("midld_strobes", {27'd0, rwe, mwe, ren, ret, ill}, 32'd0);
    chk("midld_rd", {27'd0, rd}, 32'd0);
    chk("midld_cnt", icnt, 32'd0);
    @(negedge clk) rst = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rwe || ret) n++;
    end
    chk("midld_no_wb", n, 32'd0);

    // Wrap instance: ADDI x1,x0,5 at pc=0xFFFFFFFC, then LW with MEM_LAT=1.
    @(negedge clk);
    wbus.instr = 32'h00500093; wbus.instr_valid = 1'b1;
    @(posedge clk);
    #1 wbus.instr_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addi_strobe", {30'd0, w_rwe, w_ret}, 32'd3);
    chk("wrap_addi_imm", {20'd0, w_imm}, 32'd5);
    @(negedge clk);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_ready", {31'd0, wbus.instr_ready}, 32'd1);
    wbus.instr = 32'h0040A283; wbus.instr_valid = 1'b1;
    @(posedge clk);
    #1 wbus.instr_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (w_ren) n++;
      if (i == 2) chk("wrap_lw_wb", {29'd0, w_ren, w_rwe, w_ret}, 32'd7);
    end
    chk("wrap_lw_len", n, 32'd3);
    chk("wrap_lw_pc", w_pc, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
